// File: rtl/mem_access_unit.sv
// Multicycle load/store unit: alignment check, req/ack handshake with timeout,
// lane-based byte enables, replicated store data and an extended load result.
module mem_access_unit #(
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [5:0]      op,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic            busy,
    output logic            done,
    output logic [1:0]      err,
    output logic [31:0]     rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [31:0]     mem_addr,
    output logic [DW/8-1:0] mem_be,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int unsigned BW   = DW / 8;
    localparam int unsigned LN_W = $clog2(BW);
    localparam int unsigned CW   = 8;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_MIS = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;
    localparam logic [1:0] ERR_OP  = 2'b11;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [2:0]        ld_sel_q;
    logic [LN_W-1:0]   lane_q;
    logic [CW-1:0]     wait_q;

    logic [1:0]        req_err_c;
    logic [1:0]        req_size_c;
    logic              req_store_c;
    logic [3:0]        be_mask_c;
    logic [BW-1:0]     be_c;
    logic [DW-1:0]     wdata_rep_c;
    logic [31:0]       lane_word_c;
    logic [31:0]       load_c;

    // Classify the incoming request: size, direction, and error status.
    always_comb begin
        req_err_c   = ERR_OK;
        req_size_c  = SZ_B;
        req_store_c = 1'b0;
        case (op)
            6'b100000, 6'b100100: req_size_c = SZ_B;
            6'b100001, 6'b100101: req_size_c = SZ_H;
            6'b100011:            req_size_c = SZ_W;
            6'b101000: begin req_size_c = SZ_B; req_store_c = 1'b1; end
            6'b101001: begin req_size_c = SZ_H; req_store_c = 1'b1; end
            6'b101011: begin req_size_c = SZ_W; req_store_c = 1'b1; end
            default:              req_err_c = ERR_OP;
        endcase
        if (req_err_c == ERR_OK) begin
            if ((req_size_c == SZ_H && addr[0]) ||
                (req_size_c == SZ_W && addr[1:0] != 2'b00)) begin
                req_err_c = ERR_MIS;
            end
        end
    end

    // Byte enables and lane-replicated store data for the captured access.
    always_comb begin
        be_mask_c   = 4'b1111;
        wdata_rep_c = {(BW / 4){wdata}};
        case (req_size_c)
            SZ_B: begin
                be_mask_c   = 4'b0001;
                wdata_rep_c = {BW{wdata[7:0]}};
            end
            SZ_H: begin
                be_mask_c   = 4'b0011;
                wdata_rep_c = {(BW / 2){wdata[15:0]}};
            end
            default: ;
        endcase
        be_c = BW'(BW'(be_mask_c) << addr[LN_W-1:0]);
    end

    // Pull the addressed lane down to bit 0 and extend by load type.
    always_comb begin
        lane_word_c = 32'(mem_rdata >> {lane_q, 3'b000});
        case (ld_sel_q)
            3'b000:  load_c = {{24{lane_word_c[7]}}, lane_word_c[7:0]};
            3'b001:  load_c = {{16{lane_word_c[15]}}, lane_word_c[15:0]};
            3'b100:  load_c = {24'h0, lane_word_c[7:0]};
            3'b101:  load_c = {16'h0, lane_word_c[15:0]};
            default: load_c = lane_word_c;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ld_sel_q  <= '0;
            lane_q    <= '0;
            wait_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= ERR_OK;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        ld_sel_q <= op[2:0];
                        lane_q   <= addr[LN_W-1:0];
                        wait_q   <= '0;
                        busy     <= 1'b1;
                        if (req_err_c != ERR_OK) begin
                            state_q <= S_DONE;
                            err     <= req_err_c;
                            done    <= 1'b1;
                        end else begin
                            state_q   <= S_REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= req_store_c;
                            mem_addr  <= addr & ~32'(BW - 1);
                            mem_be    <= be_c;
                            mem_wdata <= req_store_c ? wdata_rep_c : '0;
                        end
                    end
                end
                S_REQ: begin
                    // An ack in the final wait cycle takes priority over the timeout.
                    if (mem_ack || wait_q == CW'(MAX_WAIT - 1)) begin
                        state_q   <= S_DONE;
                        done      <= 1'b1;
                        err       <= mem_ack ? ERR_OK : ERR_TMO;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_be    <= '0;
                        mem_wdata <= '0;
                        if (mem_ack && !mem_we) begin
                            rdata <= load_c;
                        end
                    end else begin
                        wait_q <= wait_q + CW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-bit unit (MAX_WAIT=4) and a 64-bit unit (MAX_WAIT=15)
// checked every cycle against a per-access schedule model, plus literal expectations.
module tb_mem_access_unit;

    localparam int unsigned MW0 = 4;
    localparam int unsigned MW1 = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start_a [2];
    logic [5:0]  op_a    [2];
    logic [31:0] addr_a  [2];
    logic [31:0] wdata_a [2];
    logic        ack_a   [2];
    logic [63:0] mrd_a   [2];

    logic        busy0, busy1, done0, done1, req0, req1, we0, we1;
    logic [1:0]  err0, err1;
    logic [31:0] rd0, rd1, ma0, ma1, wd0;
    logic [3:0]  be0;
    logic [7:0]  be1;
    logic [63:0] wd1;

    mem_access_unit #(.DW(32), .MAX_WAIT(MW0)) u_dut32 (
        .clk(clk), .rst(rst), .start(start_a[0]), .op(op_a[0]), .addr(addr_a[0]),
        .wdata(wdata_a[0]), .busy(busy0), .done(done0), .err(err0), .rdata(rd0),
        .mem_req(req0), .mem_we(we0), .mem_addr(ma0), .mem_be(be0), .mem_wdata(wd0),
        .mem_ack(ack_a[0]), .mem_rdata(mrd_a[0][31:0])
    );

    mem_access_unit #(.DW(64), .MAX_WAIT(MW1)) u_dut64 (
        .clk(clk), .rst(rst), .start(start_a[1]), .op(op_a[1]), .addr(addr_a[1]),
        .wdata(wdata_a[1]), .busy(busy1), .done(done1), .err(err1), .rdata(rd1),
        .mem_req(req1), .mem_we(we1), .mem_addr(ma1), .mem_be(be1), .mem_wdata(wd1),
        .mem_ack(ack_a[1]), .mem_rdata(mrd_a[1])
    );

    logic        o_busy [2], o_done [2], o_req [2], o_we [2];
    logic [1:0]  o_err  [2];
    logic [31:0] o_rd   [2], o_ma [2];
    logic [7:0]  o_be   [2];
    logic [63:0] o_wd   [2];

    always_comb begin
        o_busy[0] = busy0;  o_busy[1] = busy1;
        o_done[0] = done0;  o_done[1] = done1;
        o_req[0]  = req0;   o_req[1]  = req1;
        o_we[0]   = we0;    o_we[1]   = we1;
        o_err[0]  = err0;   o_err[1]  = err1;
        o_rd[0]   = rd0;    o_rd[1]   = rd1;
        o_ma[0]   = ma0;    o_ma[1]   = ma1;
        o_be[0]   = {4'h0, be0};   o_be[1] = be1;
        o_wd[0]   = {32'h0, wd0};  o_wd[1] = wd1;
    end

    // Expected outputs for the current cycle, per unit.
    logic        e_busy [2], e_done [2], e_req [2], e_we [2];
    logic [1:0]  e_err  [2];
    logic [31:0] e_rdata[2], e_ma [2];
    logic [7:0]  e_be   [2];
    logic [63:0] e_wd   [2];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    int          obs_done_cyc, obs_ndone, obs_nreq;
    logic [31:0] obs_rd, obs_ma;
    logic [1:0]  obs_err;
    logic [7:0]  obs_be;
    logic [63:0] obs_wd;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    function automatic int op_bytes(input logic [5:0] o);
        case (o)
            6'h20, 6'h24, 6'h28: return 1;
            6'h21, 6'h25, 6'h29: return 2;
            6'h23, 6'h2B:        return 4;
            default:             return 0;
        endcase
    endfunction

    function automatic bit is_store(input logic [5:0] o);
        return (o == 6'h28) || (o == 6'h29) || (o == 6'h2B);
    endfunction

    function automatic logic [1:0] classify(input logic [5:0] o, input logic [31:0] a);
        int n;
        n = op_bytes(o);
        if (n == 0) return 2'b11;
        if ((a % n) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] extract(input int dw, input logic [5:0] o,
                                            input logic [31:0] a, input logic [63:0] m);
        int b, n;
        logic [31:0] v;
        b = int'(a % (dw / 8));
        n = op_bytes(o);
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = m[8*(b+i) +: 8];
        if ((o == 6'h20 || o == 6'h21) && v[8*n-1])
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [7:0] model_be(input int dw, input logic [5:0] o, input logic [31:0] a);
        int b;
        logic [7:0] be;
        b = int'(a % (dw / 8));
        be = '0;
        for (int i = 0; i < op_bytes(o); i++) be[b+i] = 1'b1;
        return be;
    endfunction

    function automatic logic [63:0] model_wd(input int dw, input logic [5:0] o, input logic [31:0] w);
        int n;
        logic [63:0] r;
        n = op_bytes(o);
        r = '0;
        for (int i = 0; i < dw / 8; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
        return r;
    endfunction

    task automatic set_idle(input int d);
        e_busy[d] = 1'b0; e_done[d] = 1'b0; e_req[d] = 1'b0; e_we[d] = 1'b0; e_be[d] = '0;
    endtask

    // Every-cycle comparison of both units against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("busy%0d", d),  64'(o_busy[d]), 64'(e_busy[d]));
                chk($sformatf("done%0d", d),  64'(o_done[d]), 64'(e_done[d]));
                chk($sformatf("err%0d", d),   64'(o_err[d]),  64'(e_err[d]));
                chk($sformatf("rdata%0d", d), 64'(o_rd[d]),   64'(e_rdata[d]));
                chk($sformatf("req%0d", d),   64'(o_req[d]),  64'(e_req[d]));
                chk($sformatf("be%0d", d),    64'(o_be[d]),   64'(e_be[d]));
                if (e_req[d]) begin
                    chk($sformatf("we%0d", d),    64'(o_we[d]), 64'(e_we[d]));
                    chk($sformatf("maddr%0d", d), 64'(o_ma[d]), 64'(e_ma[d]));
                    if (e_we[d]) chk($sformatf("wdata%0d", d), o_wd[d], e_wd[d]);
                end
            end
        end
    end

    // One access on unit d; ack_cyc = cycle (1 = first REQ cycle) of mem_ack, 0 = never.
    task automatic access(input int d, input logic [5:0] o, input logic [31:0] a,
                          input logic [31:0] wd, input int ack_cyc,
                          input logic [63:0] rdv, input bit extra_start);
        int dw, mw, last_req, dc;
        logic [1:0]  cls, new_err;
        logic [31:0] new_rd;
        dw = (d == 0) ? 32 : 64;
        mw = (d == 0) ? int'(MW0) : int'(MW1);
        cls = classify(o, a);
        new_rd = e_rdata[d];
        last_req = 0;
        if (cls != 2'b00) begin
            new_err = cls;
            dc = 1;
        end else begin
            if (ack_cyc >= 1 && ack_cyc <= mw) begin
                last_req = ack_cyc;
                new_err = 2'b00;
                if (!is_store(o)) new_rd = extract(dw, o, a, rdv);
            end else begin
                last_req = mw;
                new_err = 2'b10;
            end
            dc = last_req + 1;
        end
        obs_ndone = 0; obs_nreq = 0; obs_done_cyc = -1;
        start_a[d] = 1'b1; op_a[d] = o; addr_a[d] = a; wdata_a[d] = wd;
        for (int t = 1; t <= dc + 1; t++) begin
            @(posedge clk); #1;
            if (o_done[d]) begin
                obs_ndone++;
                if (obs_done_cyc < 0) obs_done_cyc = t;
                obs_rd = o_rd[d];
                obs_err = o_err[d];
            end
            if (o_req[d]) begin
                if (obs_nreq == 0) begin
                    obs_be = o_be[d]; obs_wd = o_wd[d]; obs_ma = o_ma[d];
                end
                obs_nreq++;
            end
            start_a[d] = extra_start && (t == 2);
            op_a[d] = 6'h3F; addr_a[d] = 32'hFFFF_FFFF; wdata_a[d] = 32'h0;
            ack_a[d] = (t == ack_cyc);
            mrd_a[d] = (t == ack_cyc) ? rdv : 64'hDEAD_BEEF_0BAD_F00D;
            if (t <= last_req) begin
                e_busy[d] = 1'b1; e_done[d] = 1'b0; e_req[d] = 1'b1;
                e_we[d] = is_store(o);
                e_ma[d] = a & ~32'(dw / 8 - 1);
                e_be[d] = model_be(dw, o, a);
                e_wd[d] = model_wd(dw, o, wd);
            end else if (t == dc) begin
                e_busy[d] = 1'b1; e_done[d] = 1'b1; e_req[d] = 1'b0; e_we[d] = 1'b0;
                e_be[d] = '0; e_err[d] = new_err; e_rdata[d] = new_rd;
            end else begin
                set_idle(d);
            end
        end
    endtask

    task automatic reset_mid();
        int nd;
        start_a[0] = 1'b1; op_a[0] = 6'h23; addr_a[0] = 32'h100; wdata_a[0] = '0;
        @(posedge clk); #1;
        start_a[0] = 1'b0;
        e_busy[0] = 1'b1; e_req[0] = 1'b1; e_we[0] = 1'b0; e_ma[0] = 32'h100; e_be[0] = 8'h0F;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            set_idle(d); e_rdata[d] = '0; e_err[d] = '0;
        end
        chk("rstmid_req", 64'(o_req[0]), 64'h0);
        chk("rstmid_rdata", 64'(o_rd[0]), 64'h0);
        chk("rstmid_busy", 64'(o_busy[0]), 64'h0);
        nd = 0;
        for (int t = 0; t < 5; t++) begin
            @(posedge clk); #1;
            if (o_done[0]) nd++;
        end
        chk("rstmid_nodone", 64'(nd), 64'h0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_a[d] = 1'b0; op_a[d] = '0; addr_a[d] = '0; wdata_a[d] = '0;
            ack_a[d] = 1'b0; mrd_a[d] = '0;
            set_idle(d); e_err[d] = '0; e_rdata[d] = '0; e_ma[d] = '0; e_wd[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_busy%0d", d),  64'(o_busy[d]), 64'h0);
            chk($sformatf("rst_done%0d", d),  64'(o_done[d]), 64'h0);
            chk($sformatf("rst_err%0d", d),   64'(o_err[d]),  64'h0);
            chk($sformatf("rst_rdata%0d", d), 64'(o_rd[d]),   64'h0);
            chk($sformatf("rst_req%0d", d),   64'(o_req[d]),  64'h0);
            chk($sformatf("rst_we%0d", d),    64'(o_we[d]),   64'h0);
            chk($sformatf("rst_maddr%0d", d), 64'(o_ma[d]),   64'h0);
            chk($sformatf("rst_be%0d", d),    64'(o_be[d]),   64'h0);
            chk($sformatf("rst_wdata%0d", d), o_wd[d],        64'h0);
        end
        rst = 1'b0;
        chk_on = 1'b1;

        access(0, 6'h20, 32'h1003, 32'h0, 1, 64'h80FF_1234, 1'b0);
        chk("lb_done_cyc", 64'(obs_done_cyc), 64'd2);
        chk("lb_rdata", 64'(obs_rd), 64'hFFFF_FF80);
        chk("lb_err", 64'(obs_err), 64'h0);

        access(1, 6'h25, 32'h0006, 32'h0, 1, 64'hABCD_0000_0000_0000, 1'b0);
        chk("lhu64_rdata", 64'(obs_rd), 64'h0000_ABCD);
        chk("lhu64_done_cyc", 64'(obs_done_cyc), 64'd2);

        access(1, 6'h29, 32'h0006, 32'h1234_5678, 2, 64'h0, 1'b0);
        chk("sh64_be", 64'(obs_be), 64'hC0);
        chk("sh64_wdata", obs_wd, 64'h5678_5678_5678_5678);
        chk("sh64_maddr", 64'(obs_ma), 64'h0);
        chk("sh64_done_cyc", 64'(obs_done_cyc), 64'd3);
        chk("sh64_rdata_kept", 64'(obs_rd), 64'h0000_ABCD);

        access(0, 6'h23, 32'h0002, 32'h0, 1, 64'h1111_1111, 1'b0);
        chk("lw_mis_done_cyc", 64'(obs_done_cyc), 64'd1);
        chk("lw_mis_err", 64'(obs_err), 64'h1);
        chk("lw_mis_nreq", 64'(obs_nreq), 64'd0);
        chk("lw_mis_rdata", 64'(obs_rd), 64'hFFFF_FF80);

        access(0, 6'h2B, 32'h0020, 32'hCAFE_F00D, 0, 64'h0, 1'b0);
        chk("sw_tmo_nreq", 64'(obs_nreq), 64'd4);
        chk("sw_tmo_done_cyc", 64'(obs_done_cyc), 64'd5);
        chk("sw_tmo_err", 64'(obs_err), 64'h2);

        access(0, 6'h2B, 32'h0020, 32'hCAFE_F00D, 4, 64'h0, 1'b0);
        chk("sw_lateack_done_cyc", 64'(obs_done_cyc), 64'd5);
        chk("sw_lateack_err", 64'(obs_err), 64'h0);
        chk("sw_lateack_wdata", obs_wd, 64'hCAFE_F00D);

        access(0, 6'h08, 32'h0000, 32'h0, 0, 64'h0, 1'b0);
        chk("badop_err", 64'(obs_err), 64'h3);
        chk("badop_done_cyc", 64'(obs_done_cyc), 64'd1);

        access(0, 6'h21, 32'h2002, 32'h0, 3, 64'h8001_7FFF, 1'b1);
        chk("lh_ndone", 64'(obs_ndone), 64'd1);
        chk("lh_rdata", 64'(obs_rd), 64'hFFFF_8001);
        chk("lh_done_cyc", 64'(obs_done_cyc), 64'd4);

        access(1, 6'h23, 32'h0104, 32'h0, 1, 64'h1122_3344_5566_7788, 1'b0);
        chk("lw64_rdata", 64'(obs_rd), 64'h1122_3344);
        chk("lw64_be", 64'(obs_be), 64'hF0);

        access(1, 6'h20, 32'h0007, 32'h0, 1, 64'h7F00_0000_0000_0000, 1'b0);
        chk("lb64_rdata", 64'(obs_rd), 64'h0000_007F);

        access(1, 6'h28, 32'h0003, 32'h0000_00AB, 1, 64'h0, 1'b0);
        chk("sb64_be", 64'(obs_be), 64'h08);
        chk("sb64_wdata", obs_wd, 64'hABAB_ABAB_ABAB_ABAB);

        access(1, 6'h21, 32'h0005, 32'h0, 1, 64'h0, 1'b0);
        chk("lh64_mis_err", 64'(obs_err), 64'h1);
        access(1, 6'h23, 32'h0102, 32'h0, 1, 64'h0, 1'b0);
        chk("lw64_mis_err", 64'(obs_err), 64'h1);

        access(0, 6'h24, 32'h0001, 32'h0, 2, 64'h0000_FE00, 1'b0);
        chk("lbu_rdata", 64'(obs_rd), 64'h0000_00FE);

        reset_mid();

        access(1, 6'h23, 32'h0040, 32'h0, 0, 64'h0, 1'b0);
        chk("lw64_tmo_done_cyc", 64'(obs_done_cyc), 64'd16);
        chk("lw64_tmo_nreq", 64'(obs_nreq), 64'd15);
        chk("lw64_tmo_err", 64'(obs_err), 64'h2);
        chk("lw64_tmo_rdata", 64'(obs_rd), 64'h0);

        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
